// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings and defaults for the memory access unit
package mem_pkg;
    localparam int MEM_WORDS_DEFAULT = 128;
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP
    } state_e;
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: core request/response and word-memory bus of the access unit
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        MemToWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    modport slave (
        input  req, we, size, sign_ext, addr, wdata, ReadData,
        output busy, done, err, rdata, MemToWrite, Address, WriteData
    );
    modport master (
        output req, we, size, sign_ext, addr, wdata, ReadData,
        input  busy, done, err, rdata, MemToWrite, Address, WriteData
    );
endinterface

// File: rtl/byte_lane.sv
// byte_lane: little-endian lane extract/extend for loads and lane merge for sub-word stores
module byte_lane
    import mem_pkg::*;
(
    input  logic [31:0] rword,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merge_val
);
    logic [7:0]  b;
    logic [15:0] h;
    logic [4:0]  sh;
    logic [31:0] m;
    // pick the addressed lane and build the merged store word
    always_comb begin
        b = rword[{lane, 3'b000} +: 8];
        h = lane[1] ? rword[31:16] : rword[15:0];
        load_val = size == SZ_BYTE ? {{24{sign_ext & b[7]}}, b} :
                   size == SZ_HALF ? {{16{sign_ext & h[15]}}, h} : rword;
        sh = size == SZ_HALF ? {lane[1], 4'b0000} : {lane, 3'b000};
        m = (size == SZ_HALF ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
        merge_val = (rword & ~m) | ((wdata << sh) & m);
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store unit over a word-addressed memory
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input logic clk,
    input logic reset,
    mem_access_unit_if.slave bus
);
    localparam logic [31:0] LIMIT = 32'(MEM_WORDS);
    state_e      state, nxt;
    logic [31:0] addr_r, wdata_r, merge_r, rdata_r, load_val, merge_val;
    logic [1:0]  size_r;
    logic        we_r, sx_r, err_r, req_err, mem_phase;
    assign req_err = bus.size == SZ_ILL ||
                     (bus.size == SZ_HALF && bus.addr[0]) ||
                     (bus.size == SZ_WORD && bus.addr[1:0] != 2'b00) ||
                     {2'b00, bus.addr[31:2]} >= LIMIT;
    byte_lane u_lane (
        .rword(bus.ReadData),
        .lane(addr_r[1:0]),
        .size(size_r),
        .sign_ext(sx_r),
        .wdata(wdata_r),
        .load_val(load_val),
        .merge_val(merge_val)
    );
    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= nxt;
    end
    // next-state: errors skip straight to the response, word stores skip the read
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (bus.req) nxt = req_err ? RESP : !bus.we ? LOAD :
                                        bus.size == SZ_WORD ? WRITE : RMW_RD;
            LOAD:    nxt = RESP;
            RMW_RD:  nxt = WRITE;
            WRITE:   nxt = RESP;
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    // request latch, load result and read-modify-write merge word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r  <= '0;
            wdata_r <= '0;
            size_r  <= '0;
            we_r    <= 1'b0;
            sx_r    <= 1'b0;
            err_r   <= 1'b0;
            merge_r <= '0;
            rdata_r <= '0;
        end else begin
            if (state == IDLE && bus.req) begin
                addr_r  <= bus.addr;
                wdata_r <= bus.wdata;
                size_r  <= bus.size;
                we_r    <= bus.we;
                sx_r    <= bus.sign_ext;
                err_r   <= req_err;
            end
            if (state == LOAD) rdata_r <= load_val;
            if (state == RMW_RD) merge_r <= merge_val;
        end
    end
    // outputs decode from state so reset clears them immediately
    always_comb begin
        mem_phase      = state == LOAD || state == RMW_RD || state == WRITE;
        bus.busy       = state != IDLE;
        bus.done       = state == RESP;
        bus.err        = state == RESP && err_r;
        bus.rdata      = rdata_r;
        bus.Address    = mem_phase ? {2'b00, addr_r[31:2]} : '0;
        bus.MemToWrite = state == WRITE && !we_r ? 1'b0 : state == WRITE;
        bus.WriteData  = state == WRITE ? (size_r == SZ_WORD ? wdata_r : merge_r) : '0;
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: vector table, reset-abort sequence and randomized model check
module tb_mem_access_unit;
    logic clk, reset;
    int checks = 0, failures = 0, wr_count = 0, done_count = 0;
    logic [31:0] mem  [128];
    logic [31:0] refm [128];
    logic [31:0] mrd;
    mem_access_unit_if bus ();
    mem_access_unit #(.MEM_WORDS(128)) dut (.clk(clk), .reset(reset), .bus(bus));
    assign bus.ReadData = bus.Address < 32'd128 ? mem[bus.Address[6:0]] : 32'h0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (bus.MemToWrite) begin
            mem[bus.Address[6:0]] <= bus.WriteData;
            wr_count <= wr_count + 1;
        end
        if (bus.done) done_count <= done_count + 1;
    end
    function automatic logic [31:0] pattern(int i);
        logic [7:0] k = 8'(i);
        return {k, ~k, k ^ 8'h5A, 8'h3C};
    endfunction
    initial for (int i = 0; i < 128; i++) mem[i] <= i == 5 ? 32'h8899AABB : pattern(i);
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask
    function automatic logic ref_err(logic [1:0] sz, logic [31:0] a);
        return sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a % 4 != 0) || a / 4 >= 128;
    endfunction
    function automatic int ref_lat(logic w, logic [1:0] sz, logic [31:0] a);
        return ref_err(sz, a) ? 1 : !w ? 2 : sz == 2'd2 ? 2 : 3;
    endfunction
    function automatic logic [31:0] ref_load(logic [1:0] sz, logic sx, logic [31:0] a);
        longint v = 0;
        int n = 1 << sz;
        for (int i = 0; i < n; i++) begin
            logic [31:0] ba = a + 32'(i);
            v |= longint'((refm[ba[8:2]] >> (8 * ba[1:0])) & 32'hFF) << (8 * i);
        end
        if (sx && v[8 * n - 1]) v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction
    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < (1 << sz); i++) begin
            logic [31:0] ba = a + 32'(i);
            refm[ba[8:2]][8 * ba[1:0] +: 8] = wd[8 * i +: 8];
        end
    endtask
    task automatic run_op(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic e, output logic [31:0] rd, output int lat, output int nwr);
        int w0;
        @(negedge clk);
        w0 = wr_count;
        bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sign_ext = sx; bus.addr = a; bus.wdata = wd;
        @(posedge clk); #1;
        bus.req = 1'b0;
        lat = 1;
        while (!bus.done && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        e = bus.err;
        rd = bus.rdata;
        nwr = wr_count - w0;
        @(posedge clk); #1;
        chk("done_one_cycle", {31'b0, bus.done | bus.busy}, 32'd0);
    endtask
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sx;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        logic [31:0] mem5;
    } vec_t;
    vec_t tbl [16];
    initial begin
        logic e;
        logic [31:0] rd, a, wd;
        logic [1:0] sz;
        logic w, sx, ee;
        int lat, nwr, d0, w0, off;
        tbl[0]  = '{1'b0, 2'd2, 1'b0, 32'h14,  32'h0,        1'b0, 32'h8899AABB, 2, 32'h8899AABB};
        tbl[1]  = '{1'b0, 2'd0, 1'b1, 32'h15,  32'h0,        1'b0, 32'hFFFFFFAA, 2, 32'h8899AABB};
        tbl[2]  = '{1'b0, 2'd0, 1'b0, 32'h15,  32'h0,        1'b0, 32'h000000AA, 2, 32'h8899AABB};
        tbl[3]  = '{1'b1, 2'd0, 1'b0, 32'h16,  32'h11,       1'b0, 32'h000000AA, 3, 32'h8811AABB};
        tbl[4]  = '{1'b0, 2'd1, 1'b0, 32'h13,  32'h0,        1'b1, 32'h000000AA, 1, 32'h8811AABB};
        tbl[5]  = '{1'b0, 2'd2, 1'b0, 32'h200, 32'h0,        1'b1, 32'h000000AA, 1, 32'h8811AABB};
        tbl[6]  = '{1'b0, 2'd1, 1'b1, 32'h16,  32'h0,        1'b0, 32'hFFFF8811, 2, 32'h8811AABB};
        tbl[7]  = '{1'b1, 2'd2, 1'b0, 32'h14,  32'h12345678, 1'b0, 32'hFFFF8811, 2, 32'h12345678};
        tbl[8]  = '{1'b0, 2'd3, 1'b0, 32'h14,  32'h0,        1'b1, 32'hFFFF8811, 1, 32'h12345678};
        tbl[9]  = '{1'b1, 2'd1, 1'b0, 32'h14,  32'hABCDCAFE, 1'b0, 32'hFFFF8811, 3, 32'h1234CAFE};
        tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h14,  32'h0,        1'b0, 32'h1234CAFE, 2, 32'h1234CAFE};
        tbl[11] = '{1'b1, 2'd2, 1'b0, 32'h15,  32'hDEADBEEF, 1'b1, 32'h1234CAFE, 1, 32'h1234CAFE};
        tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h1FC, 32'h0,        1'b0, 32'h7F80253C, 2, 32'h1234CAFE};
        tbl[13] = '{1'b0, 2'd1, 1'b1, 32'h1FE, 32'h0,        1'b0, 32'h00007F80, 2, 32'h1234CAFE};
        tbl[14] = '{1'b1, 2'd0, 1'b0, 32'h17,  32'hFFFFFF99, 1'b0, 32'h00007F80, 3, 32'h9934CAFE};
        tbl[15] = '{1'b0, 2'd0, 1'b1, 32'h17,  32'h0,        1'b0, 32'hFFFFFF99, 2, 32'h9934CAFE};
        for (int i = 0; i < 128; i++) refm[i] = i == 5 ? 32'h8899AABB : pattern(i);
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'd0; bus.sign_ext = 1'b0;
        bus.addr = '0; bus.wdata = '0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done_err", {30'b0, bus.done, bus.err}, 32'd0);
        chk("rst_memwr", {31'b0, bus.MemToWrite}, 32'd0);
        chk("rst_address", bus.Address, 32'd0);
        chk("rst_writedata", bus.WriteData, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        foreach (tbl[i]) begin
            run_op(tbl[i].we, tbl[i].size, tbl[i].sx, tbl[i].addr, tbl[i].wdata, e, rd, lat, nwr);
            chk($sformatf("tbl%0d_err", i), {31'b0, e}, {31'b0, tbl[i].err});
            chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rdata);
            chk($sformatf("tbl%0d_writes", i), nwr, (tbl[i].we && !tbl[i].err) ? 1 : 0);
            chk($sformatf("tbl%0d_mem5", i), mem[5], tbl[i].mem5);
            if (tbl[i].we && !tbl[i].err) ref_store(tbl[i].size, tbl[i].addr, tbl[i].wdata);
        end
        @(negedge clk);
        d0 = done_count; w0 = wr_count;
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd0; bus.addr = 32'h16; bus.wdata = 32'h77;
        @(posedge clk); #1;
        bus.req = 1'b0;
        chk("abort_in_rmw_addr", bus.Address, 32'd5);
        #1 reset = 1'b1;
        #1;
        chk("abort_busy", {31'b0, bus.busy}, 32'd0);
        chk("abort_address", bus.Address, 32'd0);
        chk("abort_rdata", bus.rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_write", wr_count - w0, 0);
        chk("abort_no_done", done_count - d0, 0);
        chk("abort_mem5", mem[5], 32'h9934CAFE);
        run_op(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, e, rd, lat, nwr);
        chk("after_abort_rdata", rd, 32'h9934CAFE);
        chk("after_abort_lat", lat, 2);
        mrd = rd;
        for (int n = 0; n < 300; n++) begin
            w = 1'($urandom_range(0, 1));
            sx = 1'($urandom_range(0, 1));
            sz = $urandom_range(0, 15) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
            off = $urandom_range(0, 3);
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) off = off & ~((1 << sz) - 1);
            a = $urandom_range(0, 19) == 0 ? $urandom : 32'($urandom_range(0, 131) * 4 + off);
            wd = $urandom;
            ee = ref_err(sz, a);
            run_op(w, sz, sx, a, wd, e, rd, lat, nwr);
            if (!ee && !w) mrd = ref_load(sz, sx, a);
            if (!ee && w) ref_store(sz, a, wd);
            chk($sformatf("rnd%0d_err", n), {31'b0, e}, {31'b0, ee});
            chk($sformatf("rnd%0d_lat", n), lat, ref_lat(w, sz, a));
            chk($sformatf("rnd%0d_rdata", n), rd, mrd);
            chk($sformatf("rnd%0d_writes", n), nwr, (w && !ee) ? 1 : 0);
            if (a / 4 < 128) chk($sformatf("rnd%0d_mem", n), mem[a[8:2]], refm[a[8:2]]);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one parameter: MEM_WORDS, default 128, the number of 32-bit words in the attached data memory.
REQ-002 clk  in  1  single clock; all state changes on posedge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req  in  1  core request; sampled only in IDLE.
REQ-005 we  in  1  1 = store, 0 = load.
REQ-006 size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-007 sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-008 addr  in  32  byte address.
REQ-009 wdata  in  32  store data, right-aligned.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 err  out  1  valid with done; 1 = access rejected.
REQ-013 rdata  out  32  last completed load result.
REQ-014 MemToWrite  out  1  memory write strobe.
REQ-015 Address  out  32  memory word index.
REQ-016 WriteData  out  32  memory write word.
REQ-017 ReadData  in  32  memory read word; combinational from Address.

Function
REQ-018 States SHALL be IDLE, LOAD, RMW_RD, WRITE and RESP.
REQ-019 In IDLE with req=1 at posedge, the block SHALL latch addr, wdata, size, we and sign_ext.
REQ-020 From that IDLE edge the next state SHALL be: error -> RESP; load -> LOAD; word store -> WRITE; byte/half store -> RMW_RD.
REQ-021 An error SHALL be any of: size=11; half with addr[0]=1; word with addr[1:0]!=0; addr[31:2] >= MEM_WORDS.
REQ-022 Address SHALL equal the latched addr[31:2], zero-extended, in LOAD, RMW_RD and WRITE, and SHALL be 0 otherwise.
REQ-023 LOAD SHALL capture the lane-extracted, extended ReadData into rdata at its posedge, then go to RESP.
REQ-024 Lanes SHALL be little-endian: byte lane = addr[1:0] at bits [8*lane+7:8*lane]; half lane = addr[1].
REQ-025 RMW_RD SHALL merge the low byte/half of wdata into ReadData at the addressed lane, store the result in a merge register, then go to WRITE.
REQ-026 In WRITE: MemToWrite=1 for exactly one cycle; WriteData = wdata for word stores or the merge register for sub-word stores; next state RESP.
REQ-027 WriteData SHALL be 0 and MemToWrite SHALL be 0 in every state other than WRITE.
REQ-028 RESP SHALL assert done=1 (plus err if flagged) for one cycle, then return to IDLE.
REQ-029 req SHALL be ignored outside IDLE.
REQ-030 Latency from the req-sampling edge to done high SHALL be: error 1 cycle; load 2 cycles; word store 2 cycles; sub-word store 3 cycles.
REQ-031 Stores and errors SHALL leave rdata unchanged.
REQ-032 An errored access SHALL never assert MemToWrite.

Reset
REQ-033 Reset SHALL force IDLE immediately, with busy, done, err, MemToWrite = 0, Address = 0, WriteData = 0 and rdata = 0.
REQ-034 Reset during any state SHALL abort the access with no memory write and no done pulse.

Structure
REQ-035 Package mem_pkg SHALL hold the size encodings, the state enum and the MEM_WORDS default.
REQ-036 Sub-module byte_lane (combinational) SHALL provide load extract/extend and store merge.
REQ-037 The FSM and registers SHALL reside in mem_access_unit.

Verification
REQ-038 Preload word 5 = 0x8899AABB; load word at addr 0x14 -> rdata = 0x8899AABB, done 2 cycles after req, err = 0.
REQ-039 Load byte at addr 0x15: sign_ext=1 -> rdata = 0xFFFFFFAA; sign_ext=0 -> rdata = 0x000000AA.
REQ-040 Store byte wdata = 0x11 at addr 0x16 -> one read of index 5, then one write of 0x8811AABB; done 3 cycles after req.
REQ-041 Load half at addr 0x13, and load word at addr 0x200 (index 128) -> done + err after 1 cycle; MemToWrite never high; rdata unchanged.
REQ-042 Start a sub-word store and assert reset in RMW_RD -> busy = 0 at once, no write, no done pulse, memory unchanged; the next request completes normally.
